// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Avalon-MM master that drives the CSR slave of an Avalon I2C host core to
// perform single-byte register writes/reads on a 7-bit-addressed I2C device.
// Brings the core up after reset, detects NACK / arbitration loss, bounds
// the busy poll with a timeout, and flushes/re-enables the core on any error.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   req_*               user request (accepted on req_valid & req_ready)
//   rsp_*               one-cycle completion pulse with read data and error
//   avm_*               Avalon-MM master to the I2C core CSR port
module i2c_reg_sequencer #(
    parameter int unsigned SCL_LOW_CNT  = 250,
    parameter int unsigned SCL_HIGH_CNT = 250,
    parameter int unsigned SDA_HOLD_CNT = 30,
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [3:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    localparam logic [ADDR_W-1:0] A_TFR_CMD  = 4'd0;
    localparam logic [ADDR_W-1:0] A_RX_DATA  = 4'd1;
    localparam logic [ADDR_W-1:0] A_CTRL     = 4'd2;
    localparam logic [ADDR_W-1:0] A_ISR      = 4'd4;
    localparam logic [ADDR_W-1:0] A_STATUS   = 4'd5;
    localparam logic [ADDR_W-1:0] A_SCL_LOW  = 4'd8;
    localparam logic [ADDR_W-1:0] A_SCL_HIGH = 4'd9;
    localparam logic [ADDR_W-1:0] A_SDA_HOLD = 4'd10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_ARBLOST = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_INIT_SCLL, S_INIT_SCLH, S_INIT_HOLD, S_INIT_EN,
        S_IDLE, S_CMD0, S_CMD1, S_CMD2, S_CMD3,
        S_POLL, S_ISR_RD, S_RX_RD, S_ISR_CLR, S_DIS, S_EN, S_RSP
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } req_t;

    state_t            state, state_n;
    req_t              req_q, req_n;
    logic [1:0]        err_q, err_n;
    logic [7:0]        rdata_q, rdata_n;
    logic [CNT_W-1:0]  poll_cnt, poll_cnt_n;

    logic              req_ready_n, rsp_valid_n;
    logic [7:0]        rsp_rdata_n;
    logic [1:0]        rsp_err_n;
    logic [ADDR_W-1:0] avm_address_n;
    logic              avm_read_n, avm_write_n;
    logic [DATA_W-1:0] avm_writedata_n;

    logic              access_done_c;
    logic              unused_rdata;

    // An access completes in the cycle its strobe is seen without waitrequest.
    assign access_done_c = (avm_read | avm_write) & ~avm_waitrequest;
    assign unused_rdata  = ^avm_readdata[31:8];

    // Next-state, latched request/result and next registered outputs.
    always_comb begin
        state_n         = state;
        req_n           = req_q;
        err_n           = err_q;
        rdata_n         = rdata_q;
        poll_cnt_n      = '0;
        req_ready_n     = 1'b0;
        rsp_valid_n     = 1'b0;
        rsp_rdata_n     = '0;
        rsp_err_n       = '0;
        avm_address_n   = '0;
        avm_read_n      = 1'b0;
        avm_write_n     = 1'b0;
        avm_writedata_n = '0;

        case (state)
            S_INIT_SCLL: if (access_done_c) state_n = S_INIT_SCLH;
            S_INIT_SCLH: if (access_done_c) state_n = S_INIT_HOLD;
            S_INIT_HOLD: if (access_done_c) state_n = S_INIT_EN;
            S_INIT_EN:   if (access_done_c) state_n = S_IDLE;
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    req_n.rw       = req_rw;
                    req_n.dev      = req_dev;
                    req_n.reg_addr = req_reg;
                    req_n.wdata    = req_wdata;
                    err_n          = ERR_OK;
                    rdata_n        = '0;
                    state_n        = S_CMD0;
                end
            end
            S_CMD0: if (access_done_c) state_n = S_CMD1;
            S_CMD1: if (access_done_c) state_n = S_CMD2;
            S_CMD2: if (access_done_c) state_n = req_q.rw ? S_CMD3 : S_POLL;
            S_CMD3: if (access_done_c) state_n = S_POLL;
            S_POLL: begin
                poll_cnt_n = (poll_cnt == CNT_MAX) ? poll_cnt : poll_cnt + CNT_W'(1);
                // Timeout is only taken on a completed read so a stalled
                // access is never abandoned mid-handshake.
                if (access_done_c) begin
                    if (!avm_readdata[0]) begin
                        state_n = S_ISR_RD;
                    end else if (poll_cnt >= TIMEOUT_LAST) begin
                        err_n   = ERR_TIMEOUT;
                        state_n = S_ISR_CLR;
                    end
                end
            end
            S_ISR_RD: begin
                if (access_done_c) begin
                    if (avm_readdata[3]) begin
                        err_n   = ERR_ARBLOST;
                        state_n = S_ISR_CLR;
                    end else if (avm_readdata[2]) begin
                        err_n   = ERR_NACK;
                        state_n = S_ISR_CLR;
                    end else begin
                        state_n = req_q.rw ? S_RX_RD : S_RSP;
                    end
                end
            end
            S_RX_RD: begin
                if (access_done_c) begin
                    rdata_n = avm_readdata[7:0];
                    state_n = S_RSP;
                end
            end
            S_ISR_CLR: if (access_done_c) state_n = S_DIS;
            S_DIS:     if (access_done_c) state_n = S_EN;
            S_EN:      if (access_done_c) state_n = S_RSP;
            S_RSP:     state_n = S_IDLE;
            default:   state_n = S_INIT_SCLL;
        endcase

        // Outputs are those of the state being entered (or held).
        case (state_n)
            S_INIT_SCLL: begin
                avm_write_n = 1'b1; avm_address_n = A_SCL_LOW;
                avm_writedata_n = DATA_W'(SCL_LOW_CNT);
            end
            S_INIT_SCLH: begin
                avm_write_n = 1'b1; avm_address_n = A_SCL_HIGH;
                avm_writedata_n = DATA_W'(SCL_HIGH_CNT);
            end
            S_INIT_HOLD: begin
                avm_write_n = 1'b1; avm_address_n = A_SDA_HOLD;
                avm_writedata_n = DATA_W'(SDA_HOLD_CNT);
            end
            S_INIT_EN, S_EN: begin
                avm_write_n = 1'b1; avm_address_n = A_CTRL;
                avm_writedata_n = DATA_W'(1);
            end
            S_IDLE: req_ready_n = 1'b1;
            S_CMD0: begin
                avm_write_n = 1'b1; avm_address_n = A_TFR_CMD;
                avm_writedata_n = DATA_W'({2'b10, req_n.dev, 1'b0});
            end
            S_CMD1: begin
                avm_write_n = 1'b1; avm_address_n = A_TFR_CMD;
                avm_writedata_n = DATA_W'(req_n.reg_addr);
            end
            S_CMD2: begin
                avm_write_n = 1'b1; avm_address_n = A_TFR_CMD;
                // Read: repeated start with R/W=1; write: data byte plus stop.
                avm_writedata_n = req_n.rw ? DATA_W'({2'b10, req_n.dev, 1'b1})
                                           : DATA_W'({2'b01, req_n.wdata});
            end
            S_CMD3: begin
                avm_write_n = 1'b1; avm_address_n = A_TFR_CMD;
                avm_writedata_n = DATA_W'({2'b01, 8'h00});
            end
            S_POLL: begin
                avm_read_n = 1'b1; avm_address_n = A_STATUS;
            end
            S_ISR_RD: begin
                avm_read_n = 1'b1; avm_address_n = A_ISR;
            end
            S_RX_RD: begin
                avm_read_n = 1'b1; avm_address_n = A_RX_DATA;
            end
            S_ISR_CLR: begin
                avm_write_n = 1'b1; avm_address_n = A_ISR;
                avm_writedata_n = DATA_W'(8'h0C);
            end
            S_DIS: begin
                avm_write_n = 1'b1; avm_address_n = A_CTRL;
                avm_writedata_n = '0;
            end
            S_RSP: begin
                rsp_valid_n = 1'b1;
                rsp_rdata_n = rdata_n;
                rsp_err_n   = err_n;
            end
            default: ;
        endcase
    end

    // State, latched request/result and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_INIT_SCLL;
            req_q         <= '0;
            err_q         <= '0;
            rdata_q       <= '0;
            poll_cnt      <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            state         <= state_n;
            req_q         <= req_n;
            err_q         <= err_n;
            rdata_q       <= rdata_n;
            poll_cnt      <= poll_cnt_n;
            req_ready     <= req_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_rdata     <= rsp_rdata_n;
            rsp_err       <= rsp_err_n;
            avm_address   <= avm_address_n;
            avm_read      <= avm_read_n;
            avm_write     <= avm_write_n;
            avm_writedata <= avm_writedata_n;
        end
    end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Avalon-MM master that configures and sequences the on-chip Avalon I2C host core (its CSR slave) to perform single-byte register writes and reads on an external 7-bit-addressed I2C device. Sits between user logic (simple request/response handshake) and the I2C core's CSR port; the core's open-drain SDA/SCL pin wrapper is unchanged. Handles core bring-up after reset, NACK/arbitration-loss detection, bus-hang timeout and core flush/recovery.

## Interface
- SCL_LOW_CNT, 250: value written to SCL_LOW (100 kHz at 50 MHz clk)
- SCL_HIGH_CNT, 250: value written to SCL_HIGH
- SDA_HOLD_CNT, 30: value written to SDA_HOLD
- TIMEOUT_CYC, 1000000: max cycles in POLL before timeout error; 20-bit counter
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe; accepted when req_valid & req_ready
- req_ready  out  1  high only in IDLE
- req_rw  in  1  1 = read, 0 = write
- req_dev  in  7  I2C device address
- req_reg  in  8  device register address
- req_wdata  in  8  write data (ignored for read)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data (0x00 for writes and errors)
- rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
- avm_address  out  4  CSR word address
- avm_read, avm_write  out  1  access strobes
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid in the cycle read is high and waitrequest low
- avm_waitrequest  in  1  stall; master holds address/strobes/data while high

## Operation
- CSR map (word): 0 TFR_CMD (bit9 STA, bit8 STO, bits7:0 byte), 1 RX_DATA, 2 CTRL (bit0 EN), 4 ISR (bit2 NACK_DET, bit3 ARBLOST_DET, write-1-to-clear), 5 STATUS (bit0 busy), 8 SCL_LOW, 9 SCL_HIGH, 10 SDA_HOLD.
- Init after reset: INIT_SCLL -> INIT_SCLH -> INIT_HOLD (write parameters) -> INIT_EN (CTRL=0x1) -> IDLE.
- Write request: CMD0 TFR_CMD={STA,dev,0}; CMD1 {reg}; CMD2 {STO,wdata}; -> POLL.
- Read request: CMD0 {STA,dev,0}; CMD1 {reg}; CMD2 {STA,dev,1} (repeated start); CMD3 {STO,0x00}; -> POLL.
- POLL: read STATUS repeatedly until bit0=0 -> ISR_RD; timeout counter increments each POLL cycle, reset on entry.
- ISR_RD: read ISR. ARBLOST set -> err 10; else NACK set -> err 01. Any error -> ISR_CLR (write 0x0C) -> DIS (CTRL=0) -> EN (CTRL=1) -> RSP. No error: read -> RX_RD (read RX_DATA, latch bits7:0) -> RSP; write -> RSP.
- Timeout in POLL -> err 11 -> ISR_CLR path (flush).
- RSP: rsp_valid=1 one cycle with rsp_rdata/rsp_err, -> IDLE.
- Request fields latched at acceptance; later changes have no effect.
- ARBLOST takes priority over NACK when both set.

## Timing
- Reset: all outputs 0 (req_ready 0, avm_* 0, rsp_* 0); state INIT_SCLL; timeout counter 0.
- Each CSR access: strobe high from state entry until the cycle waitrequest is low; state advances next cycle. No back-to-back strobes without re-evaluating waitrequest.
- Zero waitrequest: init 4 cycles, req_ready first high in cycle 5 after reset release.
- Zero waitrequest, core idle on first poll: write = 3 cmd + 1 poll + 1 ISR + RSP -> rsp_valid 6 cycles after acceptance; read = 8 cycles.
- req_valid while not IDLE: ignored, no queueing.
- Reset asserted mid-transaction: immediate return to reset values; no rsp_valid for aborted request; init re-runs.
- Timeout fires on POLL cycle TIMEOUT_CYC; counter wrap not possible.

## Test plan
- Reset release, waitrequest=0 -> writes addr 8=250, 9=250, 10=30, 2=0x1 in that order; req_ready high cycle 5.
- Write dev=0x50 reg=0x10 data=0xA5, STATUS busy 3 polls -> TFR_CMD 0x2A0, 0x010, 0x1A5; rsp_valid, err=00, rdata=0x00.
- Read dev=0x50 reg=0x22, RX_DATA=0x5C -> TFR_CMD 0x2A0, 0x022, 0x2A1, 0x100; rsp_rdata=0x5C, err=00.
- ISR returns 0x04 -> writes ISR 0x0C, CTRL 0 then 1; err=01, rdata=0x00; ISR 0x0C -> err=10.
- STATUS stuck busy, TIMEOUT_CYC=16 -> err=11 after 16 polls, flush writes seen, next request succeeds.
- Random waitrequest stalls and reset pulse mid-CMD1 -> strobes/data stable while stalled; after reset no rsp_valid, init sequence repeats.
